// File: rtl/ocp_bus_arbiter_if.sv
// OCP-style command/response channel. It carries one master/target link.
// The arbiter uses one instance per master and one toward the shared target.
interface ocp_bus_arbiter_if #(
   parameter int AW = 8,
   parameter int DW = 8
);
   logic [2:0]    MCmd;
   logic [AW-1:0] MAddr;
   logic [DW-1:0] MData;
   logic          SCmdAccept;
   logic [DW-1:0] SData;
   logic [1:0]    SResp;

   modport master (
      output MCmd, MAddr, MData,
      input  SCmdAccept, SData, SResp
   );

   modport slave (
      input  MCmd, MAddr, MData,
      output SCmdAccept, SData, SResp
   );
endinterface

// File: rtl/ocp_bus_arbiter.sv
// Two-master arbiter for a shared 8-bit OCP-style target port.
// It uses round-robin selection with an optional session lock.
// Each transaction runs through command and response phases.
// Reads that get no response within RESP_TIMEOUT cycles complete with ERR.
//
// state | meaning
// IDLE  | no owner; arbitrate between requesting masters
// CMD   | granted master's command forwarded, waiting for SCmdAccept
// RESP  | read accepted, forwarding target response or timing out
module ocp_bus_arbiter #(
   parameter int AW           = 8,
   parameter int DW           = 8,
   parameter int RESP_TIMEOUT = 255,
   parameter int TW           = 8
) (
   input  logic                clk,
   input  logic                reset_n,
   ocp_bus_arbiter_if.slave    m0,
   ocp_bus_arbiter_if.slave    m1,
   ocp_bus_arbiter_if.master   s,
   input  logic                m0_lock,
   input  logic                m1_lock,
   output logic [1:0]          grant,
   output logic                timeout_err
);

   typedef enum logic [1:0] {IDLE, CMD, RESP} state_t;

   localparam logic [2:0]    CMD_NONE = 3'd0;
   localparam logic [2:0]    CMD_RD   = 3'd2;
   localparam logic [1:0]    RESP_ERR = 2'd3;
   localparam logic [TW-1:0] TO_LAST  = TW'(RESP_TIMEOUT - 1);

   state_t        state;
   logic          last_winner;
   logic          lock_valid;
   logic          lock_id;
   logic [TW-1:0] resp_cnt;

   logic          sel;
   logic [2:0]    g_cmd;
   logic [AW-1:0] g_addr;
   logic [DW-1:0] g_data;
   logic          g_lock;
   logic          req0, req1;
   logic          lock_hold;
   logic          arb_valid, arb_id;
   logic          resp_seen, to_fire, leave;

   // The owner index follows the registered one-hot grant.
   assign sel       = grant[1];
   assign g_cmd     = sel ? m1.MCmd  : m0.MCmd;
   assign g_addr    = sel ? m1.MAddr : m0.MAddr;
   assign g_data    = sel ? m1.MData : m0.MData;
   assign g_lock    = sel ? m1_lock  : m0_lock;
   assign req0      = (m0.MCmd != CMD_NONE);
   assign req1      = (m1.MCmd != CMD_NONE);
   assign lock_hold = lock_valid && (lock_id ? m1_lock : m0_lock);
   assign resp_seen = (s.SResp != 2'd0);
   // A real response in the final cycle takes priority over the timeout.
   assign to_fire   = (state == RESP) && !resp_seen && (resp_cnt == TO_LAST);
   assign leave     = ((state == CMD) &&
                       ((g_cmd == CMD_NONE) || (s.SCmdAccept && (g_cmd != CMD_RD)))) ||
                      ((state == RESP) && (resp_seen || (resp_cnt == TO_LAST)));

   // Pick the next owner: the lock holder is exclusive, otherwise round-robin.
   always_comb begin
      arb_valid = 1'b0;
      arb_id    = 1'b0;
      if (lock_hold) begin
         arb_valid = lock_id ? req1 : req0;
         arb_id    = lock_id;
      end else if (req0 && req1) begin
         arb_valid = 1'b1;
         arb_id    = ~last_winner;
      end else if (req0) begin
         arb_valid = 1'b1;
         arb_id    = 1'b0;
      end else if (req1) begin
         arb_valid = 1'b1;
         arb_id    = 1'b1;
      end
   end

   // Route command and response signals according to the phase and the owner.
   always_comb begin
      s.MCmd        = CMD_NONE;
      s.MAddr       = '0;
      s.MData       = '0;
      m0.SCmdAccept = 1'b0;
      m0.SData      = '0;
      m0.SResp      = 2'd0;
      m1.SCmdAccept = 1'b0;
      m1.SData      = '0;
      m1.SResp      = 2'd0;
      timeout_err   = 1'b0;
      case (state)
         CMD: begin
            s.MCmd  = g_cmd;
            s.MAddr = g_addr;
            s.MData = g_data;
            if (sel) m1.SCmdAccept = s.SCmdAccept;
            else     m0.SCmdAccept = s.SCmdAccept;
         end
         RESP: begin
            timeout_err = to_fire;
            if (sel) begin
               m1.SResp = to_fire ? RESP_ERR : s.SResp;
               m1.SData = to_fire ? '0 : s.SData;
            end else begin
               m0.SResp = to_fire ? RESP_ERR : s.SResp;
               m0.SData = to_fire ? '0 : s.SData;
            end
         end
         default: ;
      endcase
   end

   // Sequencer: arbitration, phase tracking, timeout counter and lock capture.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= IDLE;
         last_winner <= 1'b1;
         lock_valid  <= 1'b0;
         lock_id     <= 1'b0;
         resp_cnt    <= '0;
         grant       <= 2'b00;
      end else if (leave) begin
         state      <= IDLE;
         grant      <= 2'b00;
         lock_valid <= g_lock;
         lock_id    <= sel;
      end else begin
         case (state)
            IDLE: begin
               if (arb_valid) begin
                  state       <= CMD;
                  last_winner <= arb_id;
                  grant       <= arb_id ? 2'b10 : 2'b01;
               end
            end
            CMD: begin
               if (s.SCmdAccept) begin
                  state    <= RESP;
                  resp_cnt <= '0;
               end
            end
            RESP: resp_cnt <= resp_cnt + TW'(1);
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ocp_bus_arbiter.sv
module tb_ocp_bus_arbiter;

   typedef struct packed {
      logic [2:0] cmd;
      logic [7:0] addr;
      logic [7:0] data;
   } cmd_t;

   typedef struct packed {
      logic       id;
      logic [1:0] resp;
      logic [7:0] data;
   } rsp_t;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       m0_lock, m1_lock;
   logic [1:0] grant;
   logic       timeout_err;

   int total = 0;
   int bad   = 0;
   int acc0  = 0;
   int acc1  = 0;
   int a0, a1;

   cmd_t cq[$];
   rsp_t rq[$];

   ocp_bus_arbiter_if #(.AW(8), .DW(8)) m0_if ();
   ocp_bus_arbiter_if #(.AW(8), .DW(8)) m1_if ();
   ocp_bus_arbiter_if #(.AW(8), .DW(8)) s_if ();

   ocp_bus_arbiter #(.AW(8), .DW(8), .RESP_TIMEOUT(8), .TW(8)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .m0          (m0_if),
      .m1          (m1_if),
      .s           (s_if),
      .m0_lock     (m0_lock),
      .m1_lock     (m1_lock),
      .grant       (grant),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      m0_if.MCmd = 3'd0; m0_if.MAddr = 8'h00; m0_if.MData = 8'h00;
      m1_if.MCmd = 3'd0; m1_if.MAddr = 8'h00; m1_if.MData = 8'h00;
      s_if.SCmdAccept = 1'b0; s_if.SData = 8'h00; s_if.SResp = 2'd0;
      m0_lock = 1'b0; m1_lock = 1'b0;
   endtask

   task automatic do_reset;
      idle_inputs();
      reset_n = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
   endtask

   // Called in a CMD cycle: accept, wait lat extra RESP cycles, answer DVA.
   task automatic serve_read(input logic [7:0] d, input int lat);
      s_if.SCmdAccept = 1'b1;
      tick();
      s_if.SCmdAccept = 1'b0;
      repeat (lat) tick();
      s_if.SResp = 2'd1;
      s_if.SData = d;
      tick();
      s_if.SResp = 2'd0;
      s_if.SData = 8'h00;
   endtask

   // Scoreboard side: accepted target commands and master responses.
   always @(negedge clk) begin
      cmd_t ec;
      rsp_t er;
      if (m0_if.SCmdAccept) acc0++;
      if (m1_if.SCmdAccept) acc1++;
      if (s_if.MCmd != 3'd0 && s_if.SCmdAccept) begin
         if (cq.size() == 0) begin
            total++; bad++;
            $error("FAIL cmd_extra observed=%0h expected=none", {s_if.MCmd, s_if.MAddr, s_if.MData});
         end else begin
            ec = cq.pop_front();
            chk("cmd_tuple", {s_if.MCmd, s_if.MAddr, s_if.MData}, ec);
         end
      end
      if (m0_if.SResp != 2'd0 || m1_if.SResp != 2'd0) begin
         if (rq.size() == 0) begin
            total++; bad++;
            $error("FAIL rsp_extra observed=%0h/%0h expected=none", m0_if.SResp, m1_if.SResp);
         end else begin
            er = rq.pop_front();
            if (er.id) begin
               chk("rsp_other_m0", m0_if.SResp, 2'd0);
               chk("rsp_m1", {m1_if.SResp, m1_if.SData}, {er.resp, er.data});
            end else begin
               chk("rsp_other_m1", m1_if.SResp, 2'd0);
               chk("rsp_m0", {m0_if.SResp, m0_if.SData}, {er.resp, er.data});
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      // ---------------- reset state
      do_reset();
      reset_n = 1'b0;
      tick();
      chk("rst_grant", grant, 2'b00);
      chk("rst_s", {s_if.MCmd, s_if.MAddr, s_if.MData}, 0);
      chk("rst_m", {m0_if.SCmdAccept, m0_if.SResp, m0_if.SData,
                    m1_if.SCmdAccept, m1_if.SResp, m1_if.SData}, 0);
      chk("rst_to", timeout_err, 1'b0);
      reset_n = 1'b1;
      tick();

      // ---------------- m0 posted write, accepted on 2nd CMD cycle
      a0 = acc0; a1 = acc1;
      m0_if.MCmd = 3'd1; m0_if.MAddr = 8'h10; m0_if.MData = 8'hA5;
      cq.push_back('{3'd1, 8'h10, 8'hA5});
      #1;
      chk("wr_idle_smcmd", s_if.MCmd, 3'd0);
      chk("wr_idle_grant", grant, 2'b00);
      tick();
      chk("wr_c1_grant", grant, 2'b01);
      chk("wr_c1_s", {s_if.MCmd, s_if.MAddr, s_if.MData}, {3'd1, 8'h10, 8'hA5});
      chk("wr_c1_acc", m0_if.SCmdAccept, 1'b0);
      tick();
      s_if.SCmdAccept = 1'b1;
      #1;
      chk("wr_c2_s", {s_if.MCmd, s_if.MAddr, s_if.MData}, {3'd1, 8'h10, 8'hA5});
      chk("wr_c2_acc0", m0_if.SCmdAccept, 1'b1);
      chk("wr_c2_acc1", m1_if.SCmdAccept, 1'b0);
      tick();
      idle_inputs();
      #1;
      chk("wr_done_grant", grant, 2'b00);
      chk("wr_done_smcmd", s_if.MCmd, 3'd0);
      tick();
      chk("wr_acc0_pulses", acc0 - a0, 1);
      chk("wr_acc1_pulses", acc1 - a1, 0);

      // ---------------- both masters read, round-robin alternation
      do_reset();
      m0_if.MCmd = 3'd2; m0_if.MAddr = 8'h20; m0_if.MData = 8'hD0;
      m1_if.MCmd = 3'd2; m1_if.MAddr = 8'h30; m1_if.MData = 8'hD1;
      cq.push_back('{3'd2, 8'h20, 8'hD0}); rq.push_back('{1'b0, 2'd1, 8'h3C});
      cq.push_back('{3'd2, 8'h30, 8'hD1}); rq.push_back('{1'b1, 2'd1, 8'h4D});
      cq.push_back('{3'd2, 8'h20, 8'hD0}); rq.push_back('{1'b0, 2'd1, 8'h11});
      cq.push_back('{3'd2, 8'h30, 8'hD1}); rq.push_back('{1'b1, 2'd1, 8'h22});
      tick();
      chk("rr_g1", grant, 2'b01);
      serve_read(8'h3C, 1);
      chk("rr_gap", grant, 2'b00);
      tick();
      chk("rr_g2", grant, 2'b10);
      serve_read(8'h4D, 0);
      tick();
      chk("rr_g3", grant, 2'b01);
      serve_read(8'h11, 2);
      tick();
      chk("rr_g4", grant, 2'b10);
      serve_read(8'h22, 0);
      idle_inputs();
      tick();

      // ---------------- lock keeps m0 for 3 transactions
      do_reset();
      m0_lock = 1'b1;
      m0_if.MCmd = 3'd2; m0_if.MAddr = 8'h20; m0_if.MData = 8'h00;
      m1_if.MCmd = 3'd2; m1_if.MAddr = 8'h30; m1_if.MData = 8'h00;
      for (int i = 0; i < 3; i++) begin
         cq.push_back('{3'd2, 8'h20, 8'h00});
         rq.push_back('{1'b0, 2'd1, 8'(8'h60 + i)});
         tick();
         chk("lock_m0", grant, 2'b01);
         serve_read(8'(8'h60 + i), 0);
      end
      m0_lock = 1'b0;
      cq.push_back('{3'd2, 8'h30, 8'h00}); rq.push_back('{1'b1, 2'd1, 8'h70});
      tick();
      chk("unlock_m1", grant, 2'b10);
      serve_read(8'h70, 0);
      idle_inputs();
      tick();

      // ---------------- m1 read timeout (RESP_TIMEOUT = 8)
      m1_if.MCmd = 3'd2; m1_if.MAddr = 8'h44;
      cq.push_back('{3'd2, 8'h44, 8'h00}); rq.push_back('{1'b1, 2'd3, 8'h00});
      tick();
      chk("to_grant", grant, 2'b10);
      s_if.SCmdAccept = 1'b1;
      tick();
      s_if.SCmdAccept = 1'b0;
      m1_if.MCmd = 3'd0;
      s_if.SData = 8'h77;
      for (int k = 1; k <= 8; k++) begin
         #1;
         chk($sformatf("to_resp_c%0d", k), m1_if.SResp, (k == 8) ? 2'd3 : 2'd0);
         chk($sformatf("to_err_c%0d", k), timeout_err, (k == 8) ? 1'b1 : 1'b0);
         if (k == 8) chk("to_sdata", m1_if.SData, 8'h00);
         else tick();
      end
      tick();
      s_if.SResp = 2'd1; s_if.SData = 8'h99;
      #1;
      chk("late_m1", m1_if.SResp, 2'd0);
      chk("late_m0", m0_if.SResp, 2'd0);
      chk("late_err", timeout_err, 1'b0);
      chk("late_grant", grant, 2'b00);
      tick();
      s_if.SResp = 2'd0; s_if.SData = 8'h00;
      m0_if.MCmd = 3'd1; m0_if.MAddr = 8'h55; m0_if.MData = 8'h66;
      cq.push_back('{3'd1, 8'h55, 8'h66});
      tick();
      chk("post_to_grant", grant, 2'b01);
      s_if.SCmdAccept = 1'b1;
      tick();
      idle_inputs();
      tick();

      // ---------------- response in the timeout cycle wins
      m0_if.MCmd = 3'd2; m0_if.MAddr = 8'h45;
      cq.push_back('{3'd2, 8'h45, 8'h00}); rq.push_back('{1'b0, 2'd1, 8'h5A});
      tick();
      s_if.SCmdAccept = 1'b1;
      tick();
      s_if.SCmdAccept = 1'b0;
      m0_if.MCmd = 3'd0;
      repeat (7) tick();
      s_if.SResp = 2'd1; s_if.SData = 8'h5A;
      #1;
      chk("tie_resp", {m0_if.SResp, m0_if.SData}, {2'd1, 8'h5A});
      chk("tie_err", timeout_err, 1'b0);
      tick();
      s_if.SResp = 2'd0; s_if.SData = 8'h00;
      tick();

      // ---------------- reset during RESP
      m0_if.MCmd = 3'd2; m0_if.MAddr = 8'h46;
      cq.push_back('{3'd2, 8'h46, 8'h00});
      tick();
      s_if.SCmdAccept = 1'b1;
      tick();
      s_if.SCmdAccept = 1'b0;
      reset_n = 1'b0;
      tick();
      s_if.SResp = 2'd1; s_if.SData = 8'hEE;
      m0_if.MCmd = 3'd1; m0_if.MAddr = 8'h01; m0_if.MData = 8'h02;
      m1_if.MCmd = 3'd2; m1_if.MAddr = 8'h02; m1_if.MData = 8'h00;
      #1;
      chk("rr_rst_grant", grant, 2'b00);
      chk("rr_rst_m0", {m0_if.SCmdAccept, m0_if.SResp, m0_if.SData}, 0);
      chk("rr_rst_s", {s_if.MCmd, s_if.MAddr, s_if.MData}, 0);
      chk("rr_rst_err", timeout_err, 1'b0);
      s_if.SResp = 2'd0; s_if.SData = 8'h00;
      reset_n = 1'b1;
      cq.push_back('{3'd1, 8'h01, 8'h02});
      tick();
      chk("after_rst_grant", grant, 2'b01);

      // ---------------- m1 drops its command before acceptance
      s_if.SCmdAccept = 1'b1;
      tick();
      s_if.SCmdAccept = 1'b0;
      m0_if.MCmd = 3'd0;
      tick();
      chk("drop_grant", grant, 2'b10);
      chk("drop_smcmd_pre", s_if.MCmd, 3'd2);
      a1 = acc1;
      m1_if.MCmd = 3'd0;
      tick();
      s_if.SCmdAccept = 1'b1;
      #1;
      chk("drop_idle_grant", grant, 2'b00);
      chk("drop_idle_smcmd", s_if.MCmd, 3'd0);
      chk("drop_idle_acc", m1_if.SCmdAccept, 1'b0);
      s_if.SCmdAccept = 1'b0;
      chk("drop_no_acc", acc1 - a1, 0);
      m1_if.MCmd = 3'd1; m1_if.MAddr = 8'h03; m1_if.MData = 8'h04;
      cq.push_back('{3'd1, 8'h03, 8'h04});
      tick();
      chk("drop_rearb", grant, 2'b10);
      s_if.SCmdAccept = 1'b1;
      tick();
      idle_inputs();
      tick();
      tick();

      chk("cmd_queue_empty", cq.size(), 0);
      chk("rsp_queue_empty", rq.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ocp_bus_arbiter.md
Name: ocp_bus_arbiter

Overview:
- Shares one 8-bit OCP-style target port (register file / peripheral bus) between two masters.
- Master 0 is the UART transaction engine; master 1 is the on-chip host/debug master.
- Round-robin arbitration, with an optional lock that lets a master keep ownership across a multi-transaction session.
- Sequences each transaction through command and response phases, with a response timeout.

Parameters:
- AW, 8, address width
- DW, 8, data width
- RESP_TIMEOUT, 255, cycles waited for a read response before returning ERR (1..2^TW-1)
- TW, 8, timeout counter width

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- m0_MCmd  in  3  master 0 command: 0 IDLE, 1 WR, 2 RD
- m0_MAddr  in  AW  master 0 address
- m0_MData  in  DW  master 0 write data
- m0_SCmdAccept  out  1  command accepted to master 0
- m0_SData  out  DW  read data to master 0
- m0_SResp  out  2  response to master 0: 0 NULL, 1 DVA, 3 ERR
- m0_lock  in  1  master 0 session lock (driven by uart_active)
- m1_MCmd, m1_MAddr, m1_MData, m1_SCmdAccept, m1_SData, m1_SResp, m1_lock  same as master 0, for master 1
- s_MCmd  out  3  command to target
- s_MAddr  out  AW  address to target
- s_MData  out  DW  write data to target
- s_SCmdAccept  in  1  target accepts command
- s_SData  in  DW  target read data
- s_SResp  in  2  target response
- grant  out  2  current owner, one-hot: 01 = m0, 10 = m1, 00 = none
- timeout_err  out  1  one-cycle pulse when a response timeout fires

Behaviour:
- Reset (reset_n low at a clk edge):
  - state = IDLE, last_winner = m1 (so m0 wins the first tie), lock_owner = none, timeout counter = 0.
  - All outputs 0: s_MCmd = 0, all SCmdAccept/SResp/SData = 0, grant = 00, timeout_err = 0.
- Outputs are combinational from registered state plus the granted master's inputs. Slave-side outputs are 0 unless the state says otherwise.
- IDLE state:
  - A master requests when its MCmd != 0.
  - If lock_owner is set and that master's lock is still high, only lock_owner may be granted.
  - Otherwise round-robin: with both requesting, the master that is not last_winner wins; with one requesting, it wins.
  - The winner is registered. Next state = CMD, last_winner is updated, grant is updated.
  - Arbitration latency: 1 cycle. Nothing is forwarded to the target in IDLE.
- CMD state:
  - s_MCmd/s_MAddr/s_MData = granted master's signals.
  - Granted master's SCmdAccept = s_SCmdAccept; the other master's SCmdAccept = 0.
  - On s_SCmdAccept = 1 with MCmd = RD: go to RESP and clear the counter.
  - On s_SCmdAccept = 1 with any other nonzero MCmd: the write is posted, no response; go to IDLE.
  - If the granted MCmd drops to 0 before acceptance (protocol violation): go to IDLE, nothing is issued.
- RESP state:
  - s_MCmd = 0.
  - Granted master's SResp/SData = s_SResp/s_SData; the other master sees 0.
  - On s_SResp != 0: go to IDLE.
  - The counter increments each RESP cycle. When it reaches RESP_TIMEOUT-1 with no response:
    - granted SResp = 3 (ERR), SData = 0, timeout_err = 1, for that single cycle;
    - next state = IDLE.
  - A late target response seen in IDLE is discarded.
- Lock:
  - On leaving CMD or RESP, lock_owner = granted master if its lock = 1, else none.
  - Lock deassertion takes effect at the next IDLE arbitration.
- grant holds its value through CMD and RESP and returns to 00 in IDLE.
- Minimum spacing: back-to-back transactions from one master cost 1 IDLE cycle between them.
- A simultaneous response and timeout in the same cycle: the response wins (DVA passed through, no timeout_err).

Test Plan:
- m0 WR addr 0x10 data 0xA5, target accepts after 2 cycles → s_MCmd = 1 / s_MAddr = 0x10 / s_MData = 0xA5 for 2 cycles; m0_SCmdAccept pulses once; grant 01 → 00; m1 sees nothing.
- m0 and m1 both RD from reset, target returns DVA 0x3C and 0x4D → m0 served first and gets 0x3C; then m1 gets 0x4D; alternation continues on sustained requests.
- m0_lock = 1 with m0 and m1 requesting continuously for 3 transactions → all 3 granted to m0; drop m0_lock → next grant goes to m1.
- m1 RD, target never responds, RESP_TIMEOUT = 8 → m1_SResp = 3 and timeout_err = 1 exactly 8 cycles after acceptance; a later DVA from the target is ignored; the next request is arbitrated normally.
- reset_n low during RESP → the following cycle all outputs are 0, grant = 00; first request after release from m0 is granted.
- m1 MCmd drops before acceptance in CMD → returns to IDLE, s_MCmd = 0 next cycle, no SCmdAccept issued.
